// File: rtl/adc_ctrl_pkg.sv
// Shared types and constants for the ADC sample-path sequencer.
package adc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_RESP,
        STORE,
        HOLD
    } state_t;

    localparam logic        ADC_CSR_ADDR         = 1'b0;
    localparam logic [31:0] ADC_CMD_START_SINGLE = 32'h0000_0003;
    localparam int          ADC_DATA_W           = 12;

endpackage

// File: rtl/adc_avg_accum.sv
// Running 2^AVG_LOG2-sample window average; publishes one avg_valid pulse per full window.
module adc_avg_accum
    import adc_ctrl_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  add,
    input  logic [ADC_DATA_W-1:0] sample,
    output logic [ADC_DATA_W-1:0] avg_out,
    output logic                  avg_valid
);

    localparam int ACC_W = ADC_DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] count;

    // Window of 2^AVG_LOG2 full-scale samples fits exactly, so no saturation is needed.
    assign sum = acc + ACC_W'(sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            count     <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (add) begin
                if (count == LAST) begin
                    avg_out   <= sum[ACC_W-1:AVG_LOG2];
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    count     <= '0;
                end else begin
                    acc   <= sum;
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/adc_seq_ctrl.sv
// ADC conversion sequencer: periodic single-shot starts, response capture into a
// wrapping sample RAM, timeout detection and a running window average.
module adc_seq_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int TIMEOUT       = 4096,
    parameter int ADDR_W        = 4,
    parameter int AVG_LOG2      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  pll_lock,
    input  logic                  clr_err,
    output logic                  csr_address,
    output logic                  csr_write,
    output logic [31:0]           csr_writedata,
    input  logic                  resp_valid,
    input  logic [ADC_DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [ADC_DATA_W-1:0] ram_data,
    output logic                  ram_wren,
    output logic [ADC_DATA_W-1:0] avg_out,
    output logic                  avg_valid,
    output logic                  timeout_err,
    output logic                  busy,
    output state_t                fsm_state
);

    localparam int CNT_MAX = (TIMEOUT > SAMPLE_PERIOD) ? TIMEOUT : SAMPLE_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(SAMPLE_PERIOD - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_W-1:0]       wr_ptr;
    logic [ADC_DATA_W-1:0]   sample;
    logic                    take;

    // A response is accepted only while waiting and locked; the average is
    // updated on the same edge so avg_valid lines up with the RAM write.
    assign take = (state == WAIT_RESP) && resp_valid && pll_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wr_ptr      <= '0;
            sample      <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (take) begin
                sample <= resp_data;
            end
            if (state == STORE) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (clr_err) begin
                timeout_err <= 1'b0;
            end
            if (!pll_lock) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state <= ARM;
                            busy  <= 1'b1;
                        end
                    end
                    ARM: begin
                        state <= WAIT_RESP;
                        cnt   <= '0;
                    end
                    WAIT_RESP: begin
                        if (resp_valid) begin
                            state <= STORE;
                        end else if (cnt == TIMEOUT_LAST) begin
                            state       <= HOLD;
                            cnt         <= '0;
                            timeout_err <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    STORE: begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            cnt <= '0;
                            if (enable) begin
                                state <= ARM;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Strobes are pure decodes of the state register, so reset kills them at once.
    assign csr_write     = (state == ARM);
    assign csr_writedata = csr_write ? ADC_CMD_START_SINGLE : 32'h0;
    assign csr_address   = ADC_CSR_ADDR;
    assign ram_wren      = (state == STORE);
    assign ram_addr      = wr_ptr;
    assign ram_data      = sample;
    assign fsm_state     = state;

    adc_avg_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk       (clk),
        .rst_n     (rst_n),
        .add       (take),
        .sample    (resp_data),
        .avg_out   (avg_out),
        .avg_valid (avg_valid)
    );

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: directed table, corner sequences and randomized conversions
// checked against a window-average / wrapping-address reference model.
module tb_adc_seq_ctrl;
    import adc_ctrl_pkg::*;

    localparam int SP  = 4;
    localparam int TO  = 16;
    localparam int AW  = 2;
    localparam int AL  = 2;
    localparam int WIN = 1 << AL;
    localparam int W   = AW + 12 + 1 + 12;

    typedef struct {
        logic [11:0]   data;
        int            lat;
        logic [AW-1:0] addr;
        logic          avv;
        logic [11:0]   avg;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, enable, pll_lock, clr_err, resp_valid;
    logic [11:0]   resp_data;
    logic          csr_address, csr_write, ram_wren, avg_valid, timeout_err, busy;
    logic [31:0]   csr_writedata;
    logic [AW-1:0] ram_addr;
    logic [11:0]   ram_data, avg_out;
    state_t        fsm_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_count = 0;
    logic [W-1:0]  exp_q[$];
    logic [11:0]   win_q[$];
    logic [W-1:0]  e;

    adc_seq_ctrl #(
        .SAMPLE_PERIOD (SP),
        .TIMEOUT       (TO),
        .ADDR_W        (AW),
        .AVG_LOG2      (AL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .pll_lock      (pll_lock),
        .clr_err       (clr_err),
        .csr_address   (csr_address),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .ram_wren      (ram_wren),
        .avg_out       (avg_out),
        .avg_valid     (avg_valid),
        .timeout_err   (timeout_err),
        .busy          (busy),
        .fsm_state     (fsm_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // reference model: every accepted sample lands at (sample index mod depth);
    // every WIN-th sample since reset closes a window whose mean is published
    function automatic void model_push(input logic [11:0] d);
        int          sum;
        logic        avv;
        logic [11:0] avg;
        avv = 1'b0;
        avg = '0;
        win_q.push_back(d);
        if (win_q.size() == WIN) begin
            sum = 0;
            foreach (win_q[i]) sum += int'(win_q[i]);
            avg = 12'(sum / WIN);
            avv = 1'b1;
            win_q.delete();
        end
        exp_q.push_back({AW'(wr_count % (1 << AW)), d, avv, avg});
        wr_count++;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        win_q.delete();
        wr_count = 0;
    endfunction

    // scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wren) begin
                if (exp_q.size() == 0) begin
                    check("spurious_wren", {31'b0, ram_wren}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_addr", 32'(ram_addr), 32'(e[W-1:25]));
                    check("sb_data", 32'(ram_data), 32'(e[24:13]));
                    check("sb_avg_valid", {31'b0, avg_valid}, {31'b0, e[12]});
                    if (e[12]) check("sb_avg_out", 32'(avg_out), 32'(e[11:0]));
                end
            end else if (avg_valid) begin
                check("stray_avg_valid", {31'b0, avg_valid}, 32'h0);
            end
            check("csr_writedata", csr_writedata, csr_write ? 32'h3 : 32'h0);
            if (csr_write) check("csr_address", {31'b0, csr_address}, 32'h0);
        end
    end

    // driver tasks
    task automatic wait_arm(output int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!csr_write && n < 100);
        check("arm_seen", {31'b0, csr_write}, 32'h1);
        c = cyc;
    endtask

    // Called at the ARM negedge; returns at the STORE negedge unless noise is set.
    task automatic conv(input logic [11:0] d, input int lat, input bit drop_en,
                        input bit noise, output int store_c);
        @(posedge clk);
        if (drop_en) begin
            #1 enable = 1'b0;
        end
        repeat (lat) @(posedge clk);
        #1;
        resp_valid = 1'b1;
        resp_data  = d;
        model_push(d);
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        resp_data  = 12'($urandom);
        @(negedge clk);
        check("store_latency", {31'b0, ram_wren}, 32'h1);
        store_c = cyc;
        if (noise) begin
            @(posedge clk);
            #1;
            resp_valid = 1'b1;
            resp_data  = 12'($urandom);
            @(posedge clk);
            #1 resp_valid = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[8];
        int   arm_c, store_c, t_en, h, n, n_arm;
        bit   prev_lost;

        tab[0] = '{12'h100, 0, 2'd0, 1'b0, 12'h000};
        tab[1] = '{12'h200, 3, 2'd1, 1'b0, 12'h000};
        tab[2] = '{12'h300, 1, 2'd2, 1'b0, 12'h000};
        tab[3] = '{12'h400, 5, 2'd3, 1'b1, 12'h280};
        tab[4] = '{12'h005, 0, 2'd0, 1'b0, 12'h000};
        tab[5] = '{12'h006, 2, 2'd1, 1'b0, 12'h000};
        tab[6] = '{12'h007, 4, 2'd2, 1'b0, 12'h000};
        tab[7] = '{12'hFFF, 1, 2'd3, 1'b1, 12'h404};

        rst_n = 1'b0; enable = 1'b0; pll_lock = 1'b0; clr_err = 1'b0;
        resp_valid = 1'b0; resp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_csr_write", {31'b0, csr_write}, 32'h0);
        check("rst_csr_data", csr_writedata, 32'h0);
        check("rst_ram_wren", {31'b0, ram_wren}, 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_data", 32'(ram_data), 32'h0);
        check("rst_avg_out", 32'(avg_out), 32'h0);
        check("rst_avg_valid", {31'b0, avg_valid}, 32'h0);
        check("rst_timeout_err", {31'b0, timeout_err}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));

        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 pll_lock = 1'b1;
        @(negedge clk);
        check("idle_without_enable", {31'b0, busy}, 32'h0);

        // enable at cycle t -> csr_write at t+1
        @(posedge clk); #1 enable = 1'b1;
        t_en = cyc;
        wait_arm(arm_c);
        check("arm_latency", 32'(arm_c - t_en), 32'h1);
        check("busy_in_arm", {31'b0, busy}, 32'h1);

        // directed table: basic window, then pointer wrap and full-scale window
        store_c = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                wait_arm(arm_c);
                check("tab_period", 32'(arm_c - store_c), 32'(SP + 1));
            end
            conv(tab[i].data, tab[i].lat, 1'b0, 1'b0, store_c);
            check("tab_addr", 32'(ram_addr), 32'(tab[i].addr));
            check("tab_data", 32'(ram_data), 32'(tab[i].data));
            check("tab_avg_valid", {31'b0, avg_valid}, {31'b0, tab[i].avv});
            if (tab[i].avv) check("tab_avg_out", 32'(avg_out), 32'(tab[i].avg));
        end

        // timeout: no response for TO cycles
        wait_arm(arm_c);
        check("pre_timeout_period", 32'(arm_c - store_c), 32'(SP + 1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < 60);
        check("timeout_latency", 32'(cyc - arm_c), 32'(TO + 1));
        h = cyc;
        @(posedge clk); #1 clr_err = 1'b1;
        @(negedge clk);
        check("err_sticky", {31'b0, timeout_err}, 32'h1);
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk);
        check("err_cleared", {31'b0, timeout_err}, 32'h0);
        wait_arm(arm_c);
        check("hold_after_timeout", 32'(arm_c - h), 32'(SP));

        // randomized conversions with one lock loss
        prev_lost = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) begin
                wait_arm(arm_c);
                if (!prev_lost) check("rand_period", 32'(arm_c - store_c), 32'(SP + 1));
            end
            if (i == 10) begin
                @(posedge clk); #1 pll_lock = 1'b0;
                @(posedge clk); #1;
                resp_valid = 1'b1;
                resp_data  = 12'($urandom);
                @(posedge clk); #1 resp_valid = 1'b0;
                @(negedge clk);
                check("lock_loss_busy", {31'b0, busy}, 32'h0);
                check("lock_loss_state", 32'(fsm_state), 32'(IDLE));
                @(posedge clk); #1 pll_lock = 1'b1;
                prev_lost = 1'b1;
                continue;
            end
            conv(12'($urandom), $urandom_range(0, 10), 1'b0, 1'($urandom_range(0, 1)), store_c);
            prev_lost = 1'b0;
        end

        // enable dropped during WAIT_RESP: finish STORE, full HOLD, then IDLE
        wait_arm(arm_c);
        check("pre_drop_period", 32'(arm_c - store_c), 32'(SP + 1));
        conv(12'($urandom), 2, 1'b1, 1'b0, store_c);
        repeat (SP) @(negedge clk);
        check("busy_in_hold", {31'b0, busy}, 32'h1);
        @(negedge clk);
        check("idle_after_drop", {31'b0, busy}, 32'h0);
        check("idle_state_after_drop", 32'(fsm_state), 32'(IDLE));
        n_arm = 0;
        repeat (12) begin
            @(negedge clk);
            if (csr_write) n_arm++;
        end
        check("no_rearm", 32'(n_arm), 32'h0);

        // reset asserted in STORE
        @(posedge clk); #1 enable = 1'b1;
        wait_arm(arm_c);
        conv(12'h5A5, 1, 1'b0, 1'b0, store_c);
        #2 rst_n = 1'b0;
        #1;
        check("rst_store_wren", {31'b0, ram_wren}, 32'h0);
        check("rst_store_busy", {31'b0, busy}, 32'h0);
        check("rst_store_avg_out", 32'(avg_out), 32'h0);
        check("rst_store_ram_addr", 32'(ram_addr), 32'h0);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        wait_arm(arm_c);
        conv(12'h123, 0, 1'b0, 1'b0, store_c);
        check("ptr_restart", 32'(ram_addr), 32'h0);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_seq_ctrl.md
# adc_seq_ctrl

Sequencing controller for the on-chip ADC sample path. It issues single-shot start commands to the ADC sequencer CSR at a programmable period and waits for each conversion response. Each sample goes into the sample RAM through a wrapping write pointer, and the block keeps a running 2^AVG_LOG2-sample average for downstream display and monitor logic. It sits between the ADC core and the sample RAM, and replaces the fixed CSR write and fixed RAM address ties in the top level.

## Interface
- SAMPLE_PERIOD, 1000: idle cycles in HOLD between the end of one conversion and the next start; minimum 1.
- TIMEOUT, 4096: cycles allowed in WAIT_RESP before a timeout is declared.
- ADDR_W, 4: sample RAM address width; depth 2^ADDR_W.
- AVG_LOG2, 3: log2 of the averaging window.

Ports:
- clk  in  1  single clock for everything: ADC CSR side, RAM and control.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request, level-sensitive.
- pll_lock  in  1  ADC PLL locked.
- clr_err  in  1  one-cycle pulse; clears timeout_err.
- csr_address  out  1  sequencer CSR address; always 0.
- csr_write  out  1  one-cycle CSR write strobe.
- csr_writedata  out  32  CSR write data; 0x00000003 (run, single-shot) during the strobe, 0 otherwise.
- resp_valid  in  1  ADC response valid.
- resp_data  in  12  ADC response data.
- ram_addr  out  ADDR_W  sample RAM address.
- ram_data  out  12  sample RAM write data.
- ram_wren  out  1  sample RAM write enable, one cycle per sample.
- avg_out  out  12  latest window average.
- avg_valid  out  1  one-cycle pulse when avg_out updates.
- timeout_err  out  1  sticky timeout flag.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ARM, WAIT_RESP, STORE, HOLD.
- IDLE: waits for enable=1 and pll_lock=1, then goes to ARM.
- ARM: drives csr_write=1 for exactly one cycle with csr_writedata=0x00000003; next state WAIT_RESP; timeout counter cleared.
- WAIT_RESP:
  - resp_valid=1: capture resp_data, go to STORE.
  - Counter reaches TIMEOUT-1 with no valid: set timeout_err, go to HOLD without writing RAM or touching the accumulator.
- STORE, one cycle:
  - ram_wren=1, ram_addr=wr_ptr, ram_data=captured sample.
  - wr_ptr increments and wraps from 2^ADDR_W-1 to 0.
  - Accumulator adds the sample; sample count increments.
- Averaging:
  - Accumulator is 12+AVG_LOG2 bits and never saturates.
  - When the sample count reaches 2^AVG_LOG2, in that same STORE cycle: avg_out <= (acc + sample) >> AVG_LOG2, avg_valid=1, accumulator and count cleared.
- HOLD: counts SAMPLE_PERIOD cycles, then goes to ARM if enable=1 and pll_lock=1, else to IDLE.
- enable deasserted mid-conversion: the current conversion completes, including STORE, then HOLD, then IDLE.
- pll_lock=0 in any state: next state is IDLE immediately. No RAM write occurs; an in-progress partial average is kept; wr_ptr is kept.
- resp_valid outside WAIT_RESP: ignored.
- clr_err and a timeout in the same cycle: the set wins.

## Timing
- Values under reset: state IDLE, every output 0, wr_ptr 0, accumulator, count and all counters 0.
- Output behaviour: all outputs are registered except the CSR and RAM strobes, which are decoded from registered state.
- enable rising while in IDLE at cycle t: csr_write=1 at t+1.
- resp_valid at t: ram_wren=1 at t+1; avg_valid (when due) also at t+1.
- Sample-to-start period: ARM, response latency, one STORE cycle, then SAMPLE_PERIOD HOLD cycles.
- Assertion of rst_n low mid-operation: outputs drop to their reset values asynchronously; no partial strobe survives.

## Structure
- Package adc_ctrl_pkg: state enum; ADC_CSR_ADDR=0; ADC_CMD_START_SINGLE=32'h00000003; ADC_DATA_W=12.
- Sub-module adc_avg_accum: accumulator, sample count and the avg_out/avg_valid register, parameterised on AVG_LOG2.
- Everything else lives in adc_seq_ctrl.

## Test plan
- Basic run: AVG_LOG2=2, SAMPLE_PERIOD=4, samples 0x100, 0x200, 0x300, 0x400 -> ram_wren at addresses 0-3 with those values; single avg_valid with avg_out=0x280.
- Wrap: ADDR_W=2, 5 samples -> 5th write goes to address 0.
- Timeout: TIMEOUT=16, never assert resp_valid -> timeout_err=1 at the 16th WAIT_RESP cycle, no ram_wren, next ARM after HOLD. Then pulse clr_err -> timeout_err=0.
- Lock loss: drop pll_lock during WAIT_RESP, then pulse resp_valid -> return to IDLE, no ram_wren, busy=0.
- Enable drop: deassert enable in WAIT_RESP, give a response -> one STORE, then HOLD, then IDLE, no further csr_write.
- Reset: assert rst_n=0 while in STORE -> ram_wren, busy and avg_out are 0 immediately; wr_ptr restarts at 0.
